// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: pipeline request/response and memory bus signals of the unified-memory arbiter
interface mem_arbiter_if;
    logic        ireq;
    logic [31:0] iaddr;
    logic        drd;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] instr;
    logic        irdy;
    logic [31:0] drdata;
    logic        drdy;
    logic        stallI;
    logic        stallM;
    logic        err;
    modport master (
        output ireq, iaddr, drd, dwe, daddr, dwdata, mem_rdata, mem_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata, instr, irdy, drdata, drdy, stallI, stallM, err
    );
    modport slave (
        input  ireq, iaddr, drd, dwe, daddr, dwdata, mem_rdata, mem_ready,
        output mem_req, mem_we, mem_addr, mem_wdata, instr, irdy, drdata, drdy, stallI, stallM, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and data sides, D first, with a watchdog
module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input logic         clk,
    input logic         reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, RESP} state_t;
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    state_t      state, stateNext;
    logic [7:0]  wdog;
    logic [31:0] memAddr, memWdata, instrReg, drdataReg;
    logic        memWe, irdyReg, drdyReg, errReg;
    logic        dreq, busy, expired, done;

    assign dreq    = bus.drd | bus.dwe;
    assign busy    = (state == IBUSY) || (state == DBUSY);
    assign expired = !bus.mem_ready && (wdog == LAST);
    assign done    = bus.mem_ready || expired;

    // state register
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= stateNext;

    // next state: D has priority in IDLE, RESP always returns to IDLE without granting
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    stateNext = dreq ? DBUSY : bus.ireq ? IBUSY : IDLE;
            IBUSY,
            DBUSY:   stateNext = done ? RESP : state;
            default: stateNext = IDLE;
        endcase
    end

    // grant latching, watchdog, data capture and one-cycle done pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog      <= '0;
            memAddr   <= '0;
            memWdata  <= '0;
            memWe     <= 1'b0;
            instrReg  <= '0;
            drdataReg <= '0;
            irdyReg   <= 1'b0;
            drdyReg   <= 1'b0;
            errReg    <= 1'b0;
        end else begin
            irdyReg <= 1'b0;
            drdyReg <= 1'b0;
            if (state == IDLE) begin
                wdog <= '0;
                if (dreq) begin
                    memAddr  <= bus.daddr;
                    memWdata <= bus.dwdata;
                    memWe    <= bus.dwe;
                end else if (bus.ireq) begin
                    memAddr <= bus.iaddr;
                    memWe   <= 1'b0;
                end
            end else if (busy) begin
                if (done) begin
                    errReg <= errReg | expired;
                    if (state == IBUSY) begin
                        instrReg <= bus.mem_ready ? bus.mem_rdata : '0;
                        irdyReg  <= 1'b1;
                    end else begin
                        drdataReg <= bus.mem_ready ? bus.mem_rdata : '0;
                        drdyReg   <= 1'b1;
                    end
                end else begin
                    wdog <= wdog + 8'd1;
                end
            end
        end
    end

    assign bus.mem_req   = busy;
    assign bus.mem_we    = memWe;
    assign bus.mem_addr  = memAddr;
    assign bus.mem_wdata = memWdata;
    assign bus.instr     = instrReg;
    assign bus.drdata    = drdataReg;
    assign bus.irdy      = irdyReg;
    assign bus.drdy      = drdyReg;
    assign bus.err       = errReg;
    assign bus.stallI    = bus.ireq & ~irdyReg;
    assign bus.stallM    = dreq & ~drdyReg;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenario checks of the memory arbiter with TIMEOUT=4
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   pulses;

    mem_arbiter_if bus ();
    mem_arbiter #(.TIMEOUT(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.ireq = 0; bus.iaddr = 0; bus.drd = 1; bus.dwe = 0; bus.daddr = 0; bus.dwdata = 0;
        bus.mem_rdata = 0; bus.mem_ready = 0;
        #2;
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%b exp=0", bus.mem_req); end
        total++; if (bus.mem_addr !== 32'h0) begin bad++; $display("FAIL rst_mem_addr got=%h exp=0", bus.mem_addr); end
        total++; if ({bus.mem_we, bus.irdy, bus.drdy, bus.err} !== 4'b0) begin bad++; $display("FAIL rst_flags got=%b exp=0000", {bus.mem_we, bus.irdy, bus.drdy, bus.err}); end
        total++; if (bus.instr !== 32'h0 || bus.drdata !== 32'h0) begin bad++; $display("FAIL rst_data got=%h/%h exp=0/0", bus.instr, bus.drdata); end
        total++; if ({bus.stallI, bus.stallM} !== 2'b01) begin bad++; $display("FAIL rst_stall got=%b exp=01", {bus.stallI, bus.stallM}); end
        bus.drd = 0;
        tick();
        tick();
        reset = 1;
        tick();
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL rst_idle got=%b exp=0", bus.mem_req); end
    endtask

    task automatic test_fetch();
        bus.ireq = 1; bus.iaddr = 32'h40;
        #1;
        total++; if (bus.stallI !== 1'b1) begin bad++; $display("FAIL fetch_stall_c0 got=%b exp=1", bus.stallI); end
        tick();
        total++; if ({bus.mem_req, bus.mem_we} !== 2'b10 || bus.mem_addr !== 32'h40) begin bad++; $display("FAIL fetch_c1 got=%b/%h exp=10/40", {bus.mem_req, bus.mem_we}, bus.mem_addr); end
        total++; if (bus.stallI !== 1'b1) begin bad++; $display("FAIL fetch_stall_c1 got=%b exp=1", bus.stallI); end
        tick();
        total++; if (bus.irdy !== 1'b0 || bus.stallI !== 1'b1) begin bad++; $display("FAIL fetch_c2 got=%b%b exp=01", bus.irdy, bus.stallI); end
        tick();
        bus.mem_ready = 1; bus.mem_rdata = 32'h2008_0005;
        #1;
        total++; if (bus.stallI !== 1'b1 || bus.mem_req !== 1'b1) begin bad++; $display("FAIL fetch_c3 got=%b%b exp=11", bus.stallI, bus.mem_req); end
        tick();
        bus.mem_ready = 0;
        total++; if (bus.irdy !== 1'b1 || bus.instr !== 32'h2008_0005) begin bad++; $display("FAIL fetch_c4 got=%b/%h exp=1/20080005", bus.irdy, bus.instr); end
        total++; if (bus.stallI !== 1'b0) begin bad++; $display("FAIL fetch_stall_c4 got=%b exp=0", bus.stallI); end
        bus.ireq = 0;
        tick();
        total++; if (bus.irdy !== 1'b0 || bus.mem_req !== 1'b0) begin bad++; $display("FAIL fetch_c5 got=%b%b exp=00", bus.irdy, bus.mem_req); end
    endtask

    task automatic test_priority();
        bus.ireq = 1; bus.iaddr = 32'h44; bus.drd = 1; bus.daddr = 32'h80;
        tick();
        total++; if (bus.mem_addr !== 32'h80 || bus.mem_req !== 1'b1) begin bad++; $display("FAIL prio_dgrant got=%h exp=80", bus.mem_addr); end
        bus.mem_ready = 1; bus.mem_rdata = 32'h1111;
        #1;
        total++; if ({bus.stallI, bus.stallM} !== 2'b11) begin bad++; $display("FAIL prio_stall_c1 got=%b exp=11", {bus.stallI, bus.stallM}); end
        tick();
        bus.mem_ready = 0;
        total++; if ({bus.drdy, bus.irdy} !== 2'b10 || bus.drdata !== 32'h1111) begin bad++; $display("FAIL prio_drdy got=%b/%h exp=10/1111", {bus.drdy, bus.irdy}, bus.drdata); end
        total++; if ({bus.stallI, bus.stallM} !== 2'b10) begin bad++; $display("FAIL prio_stall_c2 got=%b exp=10", {bus.stallI, bus.stallM}); end
        bus.drd = 0;
        tick();
        total++; if (bus.mem_req !== 1'b0 || bus.stallI !== 1'b1) begin bad++; $display("FAIL prio_idle got=%b%b exp=01", bus.mem_req, bus.stallI); end
        tick();
        total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h44) begin bad++; $display("FAIL prio_igrant got=%b/%h exp=1/44", bus.mem_req, bus.mem_addr); end
        bus.mem_ready = 1; bus.mem_rdata = 32'h2222;
        tick();
        bus.mem_ready = 0;
        total++; if (bus.irdy !== 1'b1 || bus.instr !== 32'h2222) begin bad++; $display("FAIL prio_irdy got=%b/%h exp=1/2222", bus.irdy, bus.instr); end
        bus.ireq = 0;
        tick();
    endtask

    task automatic test_store();
        bus.dwe = 1; bus.daddr = 32'h100; bus.dwdata = 32'hDEAD_BEEF;
        pulses = 0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 3) begin bus.mem_ready = 1; bus.mem_rdata = 32'h3333; end
            total++; if ({bus.mem_req, bus.mem_we} !== 2'b11 || bus.mem_wdata !== 32'hDEAD_BEEF || bus.mem_addr !== 32'h100) begin bad++; $display("FAIL store_c%0d got=%b/%h/%h exp=11/deadbeef/100", c, {bus.mem_req, bus.mem_we}, bus.mem_wdata, bus.mem_addr); end
        end
        for (int c = 4; c <= 7; c++) begin
            tick();
            bus.mem_ready = 0;
            if (c == 5) bus.dwe = 0;
            if (bus.drdy === 1'b1) pulses++;
            if (c >= 5) begin
                total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL store_regrant_c%0d got=%b exp=0", c, bus.mem_req); end
            end
        end
        total++; if (pulses != 1) begin bad++; $display("FAIL store_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_watchdog();
        bus.drd = 1; bus.daddr = 32'h200; bus.mem_rdata = 32'h5555;
        for (int c = 1; c <= 4; c++) begin
            tick();
            total++; if (bus.mem_req !== 1'b1 || bus.err !== 1'b0 || bus.drdy !== 1'b0) begin bad++; $display("FAIL wd_busy_c%0d got=%b%b%b exp=100", c, bus.mem_req, bus.err, bus.drdy); end
        end
        tick();
        total++; if (bus.err !== 1'b1 || bus.drdy !== 1'b1 || bus.drdata !== 32'h0) begin bad++; $display("FAIL wd_abort got=%b%b/%h exp=11/0", bus.err, bus.drdy, bus.drdata); end
        bus.drd = 0;
        tick();
        bus.ireq = 1; bus.iaddr = 32'h48;
        tick();
        bus.mem_ready = 1; bus.mem_rdata = 32'h4444;
        tick();
        bus.mem_ready = 0;
        total++; if (bus.irdy !== 1'b1 || bus.instr !== 32'h4444 || bus.err !== 1'b1) begin bad++; $display("FAIL wd_sticky got=%b/%h/%b exp=1/4444/1", bus.irdy, bus.instr, bus.err); end
        bus.ireq = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        bus.drd = 1; bus.daddr = 32'h300;
        tick();
        tick();
        total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL rmid_busy got=%b exp=1", bus.mem_req); end
        reset = 0;
        #1;
        total++; if ({bus.mem_req, bus.drdy, bus.err} !== 3'b000 || bus.mem_addr !== 32'h0 || bus.instr !== 32'h0) begin bad++; $display("FAIL rmid_clear got=%b/%h/%h exp=000/0/0", {bus.mem_req, bus.drdy, bus.err}, bus.mem_addr, bus.instr); end
        total++; if (bus.stallM !== 1'b1) begin bad++; $display("FAIL rmid_stall got=%b exp=1", bus.stallM); end
        tick();
        total++; if (bus.mem_req !== 1'b0 || bus.drdy !== 1'b0) begin bad++; $display("FAIL rmid_held got=%b%b exp=00", bus.mem_req, bus.drdy); end
        #2 reset = 1;
        tick();
        total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h300) begin bad++; $display("FAIL rmid_regrant got=%b/%h exp=1/300", bus.mem_req, bus.mem_addr); end
        bus.mem_ready = 1; bus.mem_rdata = 32'h6666;
        tick();
        bus.mem_ready = 0;
        total++; if (bus.drdy !== 1'b1 || bus.drdata !== 32'h6666) begin bad++; $display("FAIL rmid_done got=%b/%h exp=1/6666", bus.drdy, bus.drdata); end
        bus.drd = 0;
        tick();
    endtask

    task automatic test_spurious_ready();
        bus.mem_ready = 1; bus.mem_rdata = 32'h9999;
        tick();
        bus.mem_ready = 0;
        total++; if ({bus.mem_req, bus.irdy, bus.drdy} !== 3'b000 || bus.instr !== 32'h0 || bus.drdata !== 32'h6666) begin bad++; $display("FAIL spur_idle got=%b/%h/%h exp=000/0/6666", {bus.mem_req, bus.irdy, bus.drdy}, bus.instr, bus.drdata); end
        bus.ireq = 1; bus.iaddr = 32'h4C;
        tick();
        bus.mem_ready = 1; bus.mem_rdata = 32'hAAAA;
        tick();
        bus.mem_rdata = 32'hBBBB;
        total++; if (bus.irdy !== 1'b1 || bus.instr !== 32'hAAAA) begin bad++; $display("FAIL spur_resp got=%b/%h exp=1/aaaa", bus.irdy, bus.instr); end
        bus.ireq = 0;
        tick();
        bus.mem_ready = 0;
        total++; if ({bus.mem_req, bus.irdy} !== 2'b00 || bus.instr !== 32'hAAAA) begin bad++; $display("FAIL spur_after got=%b/%h exp=00/aaaa", {bus.mem_req, bus.irdy}, bus.instr); end
        tick();
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL spur_nogrant got=%b exp=0", bus.mem_req); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_store();
        test_watchdog();
        test_reset_mid();
        test_spurious_ready();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
